gray2bin_serial_arb: RTL and testbench
======================================

Name: gray2bin_serial_arb

Overview:
Shares one bit-serial Gray-to-binary conversion datapath between two requesters.
- A round-robin arbiter accepts one Gray word at a time over a valid/ready handshake.
- An FSM sequences the conversion MSB-first, one bit per clock.
- The binary result is presented on a held valid/ready output port.
- Sits between Gray-coded sources (e.g. async-FIFO pointers, encoders) and binary consumers.

Parameters:
WIDTH, 4, bit width of Gray input and binary output (>=2)

Ports:
clk          input   1      clock, rising edge
rst_n        input   1      reset
req0_valid   input   1      requester 0 has a Gray word
req0_gray    input   WIDTH  requester 0 Gray word
req0_ready   output  1      requester 0 word accepted this cycle
req1_valid   input   1      requester 1 has a Gray word
req1_gray    input   WIDTH  requester 1 Gray word
req1_ready   output  1      requester 1 word accepted this cycle
out_valid    output  1      result valid
out_binary   output  WIDTH  converted binary word
out_id       output  1      requester that owns the result (0/1)
out_ready    input   1      consumer accepts result
busy         output  1      high whenever state != IDLE

Interface: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE; out_valid=0, out_binary=0, out_id=0, busy=0.
  - reqN_ready=0; last_grant=1, so req0 wins the first tie.
- States: IDLE, CONV, DONE.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, for the granted requester.
  - Grant rule: only one valid -> grant it. Both valid -> grant the one != last_grant. None valid -> stay in IDLE.
  - On the accept edge: capture the Gray word into g_reg, set id_reg and last_grant to the granted id, bit index idx=WIDTH-1, go to CONV.
- CONV, one bit per cycle, MSB first:
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] XOR g[i], for idx = WIDTH-2 down to 0.
  - Decrement idx each cycle. After the idx=0 edge go to DONE.
  - Exactly WIDTH cycles in CONV.
- DONE:
  - out_valid=1; out_binary and out_id are registered.
  - All outputs stay stable until out_ready=1.
  - On the edge with out_valid && out_ready: out_valid=0, go to IDLE.
- Latency: out_valid rises WIDTH+1 edges after the accept edge.
- Throughput: one word per WIDTH+2 cycles minimum. There is always a one-cycle IDLE bubble, so no accept in the DONE cycle.
- Input stability: reqN_gray and reqN_valid changes after acceptance are ignored. A requester not granted keeps its valid asserted and is served next (no starvation).
- out_binary is undefined-free: it is cleared at reset and overwritten bit by bit during CONV. Intermediate values are not visible because out_valid=0.
- Reset mid-operation (CONV or DONE): the conversion is aborted and all state returns to reset values. No partial result is ever flagged valid.
- out_ready while out_valid=0 has no effect.

Optional Feature:
GRAY2BIN_FAST_EN
- Defined:
  - CONV lasts exactly 1 cycle; all WIDTH bits are computed in parallel (b[i] = XOR of g[WIDTH-1:i]).
  - Latency: out_valid rises 2 edges after accept. Throughput: one word per 3 cycles.
- Undefined: the bit-serial behaviour above (WIDTH cycles in CONV).
- Results, arbitration and handshakes are identical in both builds.

Test Plan:
- Reset, then req0_valid=1, req0_gray=4'b1011, out_ready=1 -> req0_ready pulses 1 cycle; out_valid after 5 edges (2 with FAST); out_binary=4'b1101, out_id=0.
- req1 only, gray=4'b1000 -> out_binary=4'b1111, out_id=1; req0_ready stays 0.
- Both valid from reset: req0=4'b0110, req1=4'b0001 -> first result 4'b0100 id=0, then 4'b0001 id=1. Repeat with both valid -> grants alternate 0,1,0,1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, out_binary, out_id held; busy=1; no reqN_ready. Raise out_ready -> one transfer, IDLE next cycle.
- rst_n pulsed low at the 2nd CONV cycle -> all outputs immediately reset; the next request after release converts correctly and req0 wins a tie.
- Exhaustive: all 16 Gray codes through req0 -> each out_binary equals the Gray-to-binary of the input; 0000->0000, 1111->1010.

Source files
------------

// File: rtl/gray2bin_serial_arb.sv
// gray2bin_serial_arb: two-requester round-robin Gray-to-binary converter (serial, or parallel with GRAY2BIN_FAST_EN)
module gray2bin_serial_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_gray,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_gray,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_binary,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nx;
  logic last_grant, grant_id, any_valid, accept, conv_last;
  logic [WIDTH-1:0] g_reg;
`ifdef GRAY2BIN_FAST_EN
  logic [WIDTH-1:0] fast_bin;
  assign conv_last = 1'b1;
  // parallel conversion: each bit is the XOR of all Gray bits at or above it
  always_comb begin
    fast_bin[WIDTH-1] = g_reg[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) fast_bin[i] = fast_bin[i+1] ^ g_reg[i];
  end
`else
  localparam int IW = $clog2(WIDTH);
  logic [IW-1:0] idx;
  logic acc, bit_nx;
  assign conv_last = (idx == '0);
  assign bit_nx = acc ^ g_reg[idx];
`endif
  // grant, handshake decode and next-state logic
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept = rst_n && (state == IDLE) && any_valid;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    busy = (state != IDLE);
    out_valid = (state == DONE);
    state_nx = (state == IDLE) ? (any_valid ? CONV : IDLE) :
               (state == CONV) ? (conv_last ? DONE : CONV) :
               (out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // capture on accept, then build the result during CONV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_reg <= '0;
      out_id <= 1'b0;
      last_grant <= 1'b1;
      out_binary <= '0;
`ifndef GRAY2BIN_FAST_EN
      idx <= '0;
      acc <= 1'b0;
`endif
    end else if (accept) begin
      g_reg <= grant_id ? req1_gray : req0_gray;
      out_id <= grant_id;
      last_grant <= grant_id;
`ifndef GRAY2BIN_FAST_EN
      idx <= IW'(WIDTH - 1);
      acc <= 1'b0;
`endif
    end else if (state == CONV) begin
`ifdef GRAY2BIN_FAST_EN
      out_binary <= fast_bin;
`else
      out_binary[idx] <= bit_nx;
      acc <= bit_nx;
      idx <= idx - 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_gray2bin_serial_arb.sv
// tb_gray2bin_serial_arb: directed self-checking bench for gray2bin_serial_arb
module tb_gray2bin_serial_arb;
`ifdef GRAY2BIN_FAST_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 5;
`endif
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, out_ready = 0;
  logic [3:0] req0_gray = 0, req1_gray = 0;
  logic req0_ready, req1_ready, out_valid, out_id, busy;
  logic [3:0] out_binary;
  int total = 0, bad = 0;
  gray2bin_serial_arb #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_gray(req0_gray), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_gray(req1_gray), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_binary(out_binary), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_one(input logic v0, input logic [3:0] g0, input logic v1, input logic [3:0] g1,
                         output logic r0, output logic r1, output int edges,
                         output logic [3:0] bin, output logic id, output logic extra_rdy);
    req0_valid = v0; req0_gray = g0; req1_valid = v1; req1_gray = g1; out_ready = 1;
    #1;
    r0 = req0_ready; r1 = req1_ready;
    tick();
    edges = 1; extra_rdy = 0;
    if (r0) begin req0_valid = 0; req0_gray = ~g0; end
    if (r1) begin req1_valid = 0; req1_gray = ~g1; end
    while (!out_valid && edges < 20) begin
      extra_rdy |= req0_ready | req1_ready;
      tick();
      edges++;
    end
    extra_rdy |= req0_ready | req1_ready;
    bin = out_binary; id = out_id;
    tick();
    req0_valid = 0; req1_valid = 0;
  endtask
  task automatic test_reset();
    req0_valid = 1; req1_valid = 1;
    tick(); #1;
    total++; if (req0_ready !== 0 || req1_ready !== 0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
    total++; if ({out_valid, out_binary, out_id, busy} !== 7'b0) begin bad++; $display("FAIL reset_out got=%b exp=0000000", {out_valid, out_binary, out_id, busy}); end
    req0_valid = 0; req1_valid = 0;
    rst_n = 1;
    tick();
  endtask
  task automatic test_req0();
    logic r0, r1, id, xr; int e; logic [3:0] b;
    run_one(1, 4'b1011, 0, 4'b0, r0, r1, e, b, id, xr);
    total++; if (r0 !== 1 || r1 !== 0) begin bad++; $display("FAIL req0_ready got=%b%b exp=10", r0, r1); end
    total++; if (xr !== 0) begin bad++; $display("FAIL req0_pulse got=%b exp=0", xr); end
    total++; if (e !== LAT) begin bad++; $display("FAIL req0_latency got=%0d exp=%0d", e, LAT); end
    total++; if (b !== 4'b1101 || id !== 0) begin bad++; $display("FAIL req0_result got=%b/%b exp=1101/0", b, id); end
    total++; if (out_valid !== 0 || busy !== 0) begin bad++; $display("FAIL req0_idle got=%b%b exp=00", out_valid, busy); end
  endtask
  task automatic test_req1();
    logic r0, r1, id, xr; int e; logic [3:0] b;
    run_one(0, 4'b0, 1, 4'b1000, r0, r1, e, b, id, xr);
    total++; if (r0 !== 0 || r1 !== 1) begin bad++; $display("FAIL req1_ready got=%b%b exp=01", r0, r1); end
    total++; if (b !== 4'b1111 || id !== 1) begin bad++; $display("FAIL req1_result got=%b/%b exp=1111/1", b, id); end
    total++; if (e !== LAT || xr !== 0) begin bad++; $display("FAIL req1_timing got=%0d/%b exp=%0d/0", e, xr, LAT); end
  endtask
  task automatic test_tie();
    logic r0, r1, id, xr; int e; logic [3:0] b;
    run_one(1, 4'b0110, 1, 4'b0001, r0, r1, e, b, id, xr);
    total++; if (r0 !== 1 || r1 !== 0 || b !== 4'b0100 || id !== 0) begin bad++; $display("FAIL tie_first got=%b%b %b/%b exp=10 0100/0", r0, r1, b, id); end
    total++; if (xr !== 0) begin bad++; $display("FAIL tie_no_ready_busy got=%b exp=0", xr); end
    run_one(0, 4'b0110, 1, 4'b0001, r0, r1, e, b, id, xr);
    total++; if (r1 !== 1 || b !== 4'b0001 || id !== 1) begin bad++; $display("FAIL tie_second got=%b %b/%b exp=1 0001/1", r1, b, id); end
  endtask
  task automatic test_alternate();
    logic r0, r1, id, xr; int e; logic [3:0] b;
    for (int k = 0; k < 4; k++) begin
      run_one(1, 4'b0011, 1, 4'b0100, r0, r1, e, b, id, xr);
      total++;
      if (id !== k[0] || b !== (k[0] ? 4'b0111 : 4'b0010)) begin
        bad++; $display("FAIL alternate_%0d got=%b/%b exp=%b/%b", k, id, b, k[0], k[0] ? 4'b0111 : 4'b0010);
      end
    end
  endtask
  task automatic test_backpressure();
    int n;
    out_ready = 0; req0_valid = 1; req0_gray = 4'b1110;
    tick();
    req0_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    total++; if (out_valid !== 1) begin bad++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (out_valid !== 1 || out_binary !== 4'b1011 || out_id !== 0 || busy !== 1 || req0_ready !== 0 || req1_ready !== 0) begin
        bad++; $display("FAIL bp_hold_%0d got=%b %b %b %b %b%b exp=1 1011 0 1 00", k, out_valid, out_binary, out_id, busy, req0_ready, req1_ready);
      end
      tick();
    end
    out_ready = 1;
    tick();
    req0_valid = 0; req1_valid = 0;
    total++; if (out_valid !== 0 || busy !== 0) begin bad++; $display("FAIL bp_release got=%b%b exp=00", out_valid, busy); end
    tick();
  endtask
  task automatic test_reset_mid();
    logic r0, r1, id, xr; int e; logic [3:0] b;
    out_ready = 1; req1_valid = 1; req1_gray = 4'b1111;
    tick();
    req1_valid = 0;
    tick();
    rst_n = 0;
    #1;
    total++; if ({out_valid, out_binary, out_id, busy, req0_ready, req1_ready} !== 9'b0) begin
      bad++; $display("FAIL midreset_out got=%b exp=000000000", {out_valid, out_binary, out_id, busy, req0_ready, req1_ready});
    end
    tick();
    rst_n = 1;
    tick();
    total++; if (out_valid !== 0 || busy !== 0) begin bad++; $display("FAIL midreset_idle got=%b%b exp=00", out_valid, busy); end
    run_one(1, 4'b1011, 1, 4'b0101, r0, r1, e, b, id, xr);
    total++; if (r0 !== 1 || b !== 4'b1101 || id !== 0 || e !== LAT) begin bad++; $display("FAIL midreset_next got=%b %b/%b %0d exp=1 1101/0 %0d", r0, b, id, e, LAT); end
  endtask
  task automatic test_exhaustive();
    logic r0, r1, id, xr; int e; logic [3:0] b;
    logic [3:0] exp_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                                 4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};
    for (int g = 0; g < 16; g++) begin
      run_one(1, 4'(g), 0, 4'b0, r0, r1, e, b, id, xr);
      total++;
      if (b !== exp_tab[g] || id !== 0 || e !== LAT) begin
        bad++; $display("FAIL exhaustive_%b got=%b/%b/%0d exp=%b/0/%0d", 4'(g), b, id, e, exp_tab[g], LAT);
      end
    end
  endtask
  initial begin
    test_reset();
    test_req0();
    test_req1();
    test_tie();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
